echo_reverb: RTL and testbench
==============================

ECHO_REVERB -- requirements
Module: echo_reverb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning signed two's-complement sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning delay-line address width, depth 2**ADDR_WIDTH samples.
REQ-003 SHALL have parameter GAIN_WIDTH, default 4, meaning unsigned feedback-gain width, Q0.GAIN_WIDTH fraction.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_data  input  DATA_WIDTH  signed dry sample x[n].
REQ-009 delay_len  input  ADDR_WIDTH  echo delay D in samples.
REQ-010 fb_gain  input  GAIN_WIDTH  feedback gain g = fb_gain / 2**GAIN_WIDTH.
REQ-011 bypass  input  1  output dry sample instead of wet.
REQ-012 out_valid  output  1  out_data valid for exactly this cycle.
REQ-013 out_data  output  DATA_WIDTH  signed output sample.
REQ-014 sat  output  1  saturation occurred on the sample in out_data.

Function
REQ-015 SHALL compute y[n] = sat(x[n] + ((g_int * y[n-Deff]) >>> GAIN_WIDTH)), g_int = fb_gain, >>> arithmetic (floor toward minus infinity), Deff = (delay_len == 0) ? 1 : delay_len.
REQ-016 SHALL form the product at full width DATA_WIDTH+GAIN_WIDTH+1 and the sum at DATA_WIDTH+1 before saturation; no intermediate truncation.
REQ-017 SHALL saturate sums above 2**(DATA_WIDTH-1)-1 or below -2**(DATA_WIDTH-1) to those limits; sat=1 with that sample, else 0.
REQ-018 SHALL store y[n] (never x[n]) in a circular delay line of 2**ADDR_WIDTH entries; write pointer wraps from 2**ADDR_WIDTH-1 to 0.
REQ-019 SHALL read from address (wr_ptr - Deff) modulo 2**ADDR_WIDTH.
REQ-020 Handshake: sample accepted when in_valid && in_ready; in_ready=1 in RUN state, independent of in_valid.
REQ-021 Latency: out_valid SHALL assert exactly 2 cycles after the accepting edge; one output per accepted sample, in order.
REQ-022 Throughput: one sample per cycle sustained; no back-pressure on output.
REQ-023 delay_len, fb_gain, bypass SHALL be sampled at the accepting edge and apply to that sample only.
REQ-024 When the read address equals an address still being written in the pipeline (Deff=1 back-to-back), SHALL forward the pending y value; result identical to unpipelined recurrence.
REQ-025 bypass=1: out_data = x[n], sat=0; y[n] still computed and written to the delay line.
REQ-026 FSM states: CLEAR, RUN.
REQ-027 CLEAR: write zero to every delay-line address, one per cycle, 2**ADDR_WIDTH cycles; in_ready=0; then go to RUN.
REQ-028 RUN: accept samples per REQ-020; stays in RUN until reset.
REQ-029 Samples in flight when reset asserts SHALL be discarded; no out_valid for them.

Reset
REQ-030 reset=1 at a clock edge SHALL set state=CLEAR, clear-address=0, wr_ptr=0, pipeline valids=0.
REQ-031 During and after reset until first output: out_valid=0, out_data=0, sat=0, in_ready=0.
REQ-032 First accepted sample after reset SHALL see all-zero history (y[n-D]=0 for all D).
REQ-033 Reset asserted mid-CLEAR SHALL restart CLEAR from address 0.

Verification
REQ-034 Clear: reset 1 cycle, ADDR_WIDTH=10 -> in_ready low 1024 cycles after reset release, then high; no out_valid meanwhile.
REQ-035 Impulse: D=4, fb_gain=8, x=1000 then zeros every cycle -> out_data 1000, 0,0,0, 500, 0,0,0, 250, ... 125, 62, 31, 15, 7, 3, 1, 0; each 2 cycles after its input.
REQ-036 Forwarding: D=0 (treated 1), fb_gain=8, x=1024 then zeros back-to-back -> 1024, 512, 256, 128, ...; negative: x=-3 -> -3, -2, -1, -1, ... (floor).
REQ-037 Saturation: D=1, fb_gain=15, x=0x7FFFFFF0 each cycle -> second output 0x7FFFFFFF with sat=1; x=0x80000000 each cycle -> 0x80000000, sat=1 from second output.
REQ-038 Bypass/wrap: bypass=1, D=1023, x=1..1100 -> out_data = x, sat=0; then bypass=0 -> output = x + (y[n-1023] * g >> 4) from stored wet history across pointer wrap.
REQ-039 Reset mid-stream: reset during continuous input -> no out_valid for in-flight samples, CLEAR rerun, first post-reset output equals its input.

Source files
------------

// File: rtl/echo_reverb_if.sv
// Streaming sample interface for the echo/reverb block: input handshake,
// per-sample controls and the output sample strobe.
interface echo_reverb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int GAIN_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] delay_len;
  logic [GAIN_WIDTH-1:0] fb_gain;
  logic                  bypass;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  sat;

  // Sample source / sink side
  modport master (
    output in_valid, in_data, delay_len, fb_gain, bypass,
    input  in_ready, out_valid, out_data, sat
  );

  // Echo/reverb block side
  modport slave (
    input  in_valid, in_data, delay_len, fb_gain, bypass,
    output in_ready, out_valid, out_data, sat
  );
endinterface

// File: rtl/echo_reverb.sv
// Feedback comb echo: y[n] = sat(x[n] + (g * y[n-D]) >>> GAIN_WIDTH).
// Wet samples live in a circular delay line that is zeroed after reset.
// Pipeline: accept edge reads history, next edge writes y and stages the
// output, the edge after that presents it (two-cycle latency).
module echo_reverb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int GAIN_WIDTH = 4
) (
  input logic          clk_i,
  input logic          reset_i,
  echo_reverb_if.slave er_if
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int GW    = GAIN_WIDTH;
  localparam int PW    = DW + GW + 1;
  localparam int SW    = DW + 1;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic          in_ready_s;
  logic          clear_we_s;
  logic          accept_s;
  logic [AW-1:0] deff_s;
  logic [AW-1:0] raddr_s;
  logic          fwd_hit_s;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_mem_q;

  // Stage 1: accepted sample and its history operand
  logic          s1_valid_q;
  logic [DW-1:0] s1_x_q;
  logic [GW-1:0] s1_gain_q;
  logic          s1_bypass_q;
  logic [AW-1:0] s1_waddr_q;
  logic          fwd_hit_q;
  logic [DW-1:0] fwd_data_q;

  // Recurrence datapath
  logic [DW-1:0]        hist_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] shift_s;
  logic [SW-1:0]        sum_s;
  logic [DW-1:0]        y_s;
  logic                 y_sat_s;

  // Stage 2 and output registers
  logic          s2_valid_q;
  logic [DW-1:0] s2_data_q;
  logic          s2_sat_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_sat_q;

  // Clamp a DW+1 bit sum into DW bits; returns {saturated, value}.
  function automatic logic [SW-1:0] saturate(input logic [SW-1:0] sum);
    logic [SW-1:0] r;
    if (sum[SW-1] != sum[SW-2]) begin
      if (sum[SW-1]) begin
        r = {1'b1, 1'b1, {(DW-1){1'b0}}};
      end else begin
        r = {1'b1, 1'b0, {(DW-1){1'b1}}};
      end
    end else begin
      r = {1'b0, sum[DW-1:0]};
    end
    return r;
  endfunction

  // State register: FSM state, clear address and write pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Next-state logic: sweep the delay line once, then run forever
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_ptr_d   = wr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = {AW{1'b0}};
        wr_ptr_d   = {AW{1'b0}};
      end
    endcase
  end

  // FSM outputs: ready only while running, zero-writes only while clearing
  always_comb begin
    in_ready_s = 1'b0;
    clear_we_s = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        in_ready_s = 1'b0;
        clear_we_s = 1'b1;
      end
      ST_RUN: begin
        in_ready_s = 1'b1;
        clear_we_s = 1'b0;
      end
      default: begin
        in_ready_s = 1'b0;
        clear_we_s = 1'b0;
      end
    endcase
    accept_s = er_if.in_valid && in_ready_s;
  end

  // Read address; a zero delay behaves as a one-sample delay
  always_comb begin
    deff_s    = (er_if.delay_len == {AW{1'b0}}) ? AW'(1) : er_if.delay_len;
    raddr_s   = wr_ptr_q - deff_s;
    fwd_hit_s = s1_valid_q && (s1_waddr_q == raddr_s);
  end

  // Delay line: zero sweep while clearing, wet y otherwise; history read on accept
  always_ff @(posedge clk_i) begin
    if (clear_we_s) begin
      mem_q[clr_addr_q] <= {DW{1'b0}};
    end else if (s1_valid_q) begin
      mem_q[s1_waddr_q] <= y_s;
    end
    if (accept_s) begin
      rd_mem_q <= mem_q[raddr_s];
    end
  end

  // Stage 1 capture; the y being written this edge is forwarded on an address hit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= {DW{1'b0}};
      s1_gain_q   <= {GW{1'b0}};
      s1_bypass_q <= 1'b0;
      s1_waddr_q  <= {AW{1'b0}};
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= {DW{1'b0}};
    end else begin
      s1_valid_q <= accept_s;
      if (accept_s) begin
        s1_x_q      <= er_if.in_data;
        s1_gain_q   <= er_if.fb_gain;
        s1_bypass_q <= er_if.bypass;
        s1_waddr_q  <= wr_ptr_q;
        fwd_hit_q   <= fwd_hit_s;
        fwd_data_q  <= y_s;
      end
    end
  end

  // Recurrence: full-width product, floor shift, widened sum, then clamp
  always_comb begin
    hist_s  = fwd_hit_q ? fwd_data_q : rd_mem_q;
    prod_s  = PW'($signed(hist_s)) * PW'($signed({1'b0, s1_gain_q}));
    shift_s = prod_s >>> GW;
    sum_s   = SW'($signed(s1_x_q)) + shift_s[SW-1:0];
    {y_sat_s, y_s} = saturate(sum_s);
  end

  // Stage 2 and output registers; bypass shows the dry sample without sat
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= {DW{1'b0}};
      s2_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_sat_q   <= 1'b0;
    end else begin
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s1_bypass_q ? s1_x_q : y_s;
        s2_sat_q  <= s1_bypass_q ? 1'b0 : y_sat_s;
      end
      if (s2_valid_q) begin
        out_data_q <= s2_data_q;
        out_sat_q  <= s2_sat_q;
      end
    end
  end

  assign er_if.in_ready  = in_ready_s;
  assign er_if.out_valid = out_valid_q;
  assign er_if.out_data  = out_data_q;
  assign er_if.sat       = out_sat_q;

endmodule

// File: tb/tb_echo_reverb.sv
// Directed bench for echo_reverb: expected outputs are queued at issue time
// and a negedge monitor checks value, sat flag and two-cycle latency.
module tb_echo_reverb;

  logic clk;
  logic reset;

  echo_reverb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .GAIN_WIDTH(4)) er_bus ();

  echo_reverb #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .GAIN_WIDTH(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .er_if   (er_bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        s;
    int          c;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  longint yh [1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value after edge k is k
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  always @(negedge clk) begin
    if (er_bus.out_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got data=%h sat=%0b at cycle %0d, required no output",
                 er_bus.out_data, er_bus.sat, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (er_bus.out_data !== mon_e.d || er_bus.sat !== mon_e.s || cyc != mon_e.c) begin
          n_fail++;
          $display("FAIL out: got data=%h sat=%0b cycle=%0d, required data=%h sat=%0b cycle=%0d",
                   er_bus.out_data, er_bus.sat, cyc, mon_e.d, mon_e.s, mon_e.c);
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [9:0] d, input logic [3:0] g,
                      input logic byp, input logic [31:0] ed, input logic es);
    int   guard;
    exp_t e;
    guard = 0;
    while (er_bus.in_ready !== 1'b1 && guard < 3000) begin
      er_bus.in_valid = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=%0b, required 1", er_bus.in_ready);
    end
    er_bus.in_valid  = 1'b1;
    er_bus.in_data   = x;
    er_bus.delay_len = d;
    er_bus.fb_gain   = g;
    er_bus.bypass    = byp;
    e.d = ed;
    e.s = es;
    e.c = cyc + 3;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    er_bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    er_bus.in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input logic keep_valid, input int exp_discard);
    int cnt;
    reset = 1'b1;
    if (!keep_valid) begin
      er_bus.in_valid = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    er_bus.in_valid = 1'b0;
    n_tests++;
    if (er_bus.out_valid !== 1'b0 || er_bus.out_data !== 32'd0 || er_bus.sat !== 1'b0 ||
        er_bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b d=%h s=%0b rdy=%0b, required all 0",
               er_bus.out_valid, er_bus.out_data, er_bus.sat, er_bus.in_ready);
    end
    cnt = 0;
    while (er_bus.in_ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt != 1024) begin
      n_fail++;
      $display("FAIL clear_len: got %0d not-ready cycles, required 1024", cnt);
    end
    n_tests++;
    if (exp_q.size() != exp_discard) begin
      n_fail++;
      $display("FAIL discard: got %0d in-flight pending, required %0d", exp_q.size(), exp_discard);
    end
    exp_q.delete();
  endtask

  int     imp_tab [11] = '{1000, 500, 250, 125, 62, 31, 15, 7, 3, 1, 0};
  int     fwd_tab [12] = '{1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0};
  int     neg_tab [5]  = '{-3, -2, -1, -1, -1};
  int     run_tab [6]  = '{1000, 1500, 1750, 1875, 1937, 1968};

  initial begin
    longint y;
    longint rd;
    logic   ys;
    int     ptr;
    reset            = 1'b1;
    er_bus.in_valid  = 1'b0;
    er_bus.in_data   = 32'd0;
    er_bus.delay_len = 10'd0;
    er_bus.fb_gain   = 4'd0;
    er_bus.bypass    = 1'b0;
    @(negedge clk);
    do_reset(1'b0, 0);

    // Impulse through a 4-sample delay at half gain
    for (int i = 0; i < 44; i++) begin
      send((i == 0) ? 32'd1000 : 32'd0, 10'd4, 4'd8, 1'b0,
           (i % 4 == 0) ? imp_tab[i / 4] : 32'd0, 1'b0);
    end
    drain();

    // Zero delay acts as one sample, back-to-back (forwarded history)
    for (int i = 0; i < 12; i++) begin
      send((i == 0) ? 32'd1024 : 32'd0, 10'd0, 4'd8, 1'b0, fwd_tab[i], 1'b0);
    end
    // Negative impulse with gaps: floor rounding via stored history
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? -32'sd3 : 32'd0, 10'd1, 4'd8, 1'b0, neg_tab[i], 1'b0);
      idle(1);
    end
    drain();

    // Positive saturation
    do_reset(1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      send(32'h7FFF_FFF0, 10'd1, 4'd15, 1'b0,
           (i == 0) ? 32'h7FFF_FFF0 : 32'h7FFF_FFFF, (i != 0));
    end
    drain();

    // Negative saturation
    do_reset(1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      send(32'h8000_0000, 10'd1, 4'd15, 1'b0, 32'h8000_0000, (i != 0));
    end
    drain();

    // Bypass over a pointer wrap, then wet output from the stored history
    do_reset(1'b0, 0);
    for (int i = 0; i < 1024; i++) yh[i] = 0;
    ptr = 0;
    for (int i = 1; i <= 1130; i++) begin
      rd = yh[(ptr - 1023) & 1023];
      y  = longint'(i) + ((8 * rd) >>> 4);
      ys = 1'b0;
      if (y > 64'sd2147483647) begin
        y  = 64'sd2147483647;
        ys = 1'b1;
      end else if (y < -64'sd2147483648) begin
        y  = -64'sd2147483648;
        ys = 1'b1;
      end
      yh[ptr & 1023] = y;
      ptr++;
      if (i <= 1100) begin
        send(32'(i), 10'd1023, 4'd8, 1'b1, 32'(i), 1'b0);
      end else begin
        send(32'(i), 10'd1023, 4'd8, 1'b0, y[31:0], ys);
      end
    end
    drain();

    // Reset during continuous input: two samples in flight are dropped
    do_reset(1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      send(32'd1000, 10'd1, 4'd8, 1'b0, run_tab[i], 1'b0);
    end
    do_reset(1'b1, 2);
    send(32'd700, 10'd1, 4'd8, 1'b0, 32'd700, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
